pmem_line_responder: RTL and testbench
======================================

Name: pmem_line_responder

Overview:
- Synthesizable physical-memory responder: the memory side of the pmem_read/pmem_write/pmem_resp line-transfer interface driven by the cache controller.
- Accepts one whole-line read or write request at a time and completes it after a fixed, parameterised latency with a single-cycle pmem_resp pulse.
- Backs a small line-granular storage array; used as the pmem model in cache-level testbenches and as an on-chip backing store.

Parameters:
- LINE_BITS, 256, bits per cache line; must be a power of two, at least 8.
- ADDR_WIDTH, 32, pmem_address width.
- DEPTH_LINES, 16, number of stored lines; must be a power of two.
- LATENCY, 4, rising edges from request acceptance to pmem_resp assertion; minimum 1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pmem_read  in  1  line read request; level, held until pmem_resp.
- pmem_write  in  1  line write request; level, held until pmem_resp.
- pmem_address  in  ADDR_WIDTH  line address; byte-offset bits are ignored.
- pmem_wdata  in  LINE_BITS  write line data.
- pmem_rdata  out  LINE_BITS  read line data; valid while pmem_resp is high.
- pmem_resp  out  1  single-cycle completion pulse.
- busy  out  1  transaction in flight (BUSY or RESP state).
- protocol_error  out  1  sticky; cleared only by reset.

Behaviour:
- Reset, asynchronous on rst_n low:
  - State is IDLE.
  - pmem_resp, busy and protocol_error are 0.
  - pmem_rdata is 0.
  - Every storage line is 0.
  - Any in-flight transaction is discarded without response or commit; pmem_resp drops immediately.
- Line index: pmem_address[OFF+IDX-1:OFF], where OFF = log2(LINE_BITS/8) and IDX = log2(DEPTH_LINES). Address bits above the index alias and are ignored.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - Exactly one of pmem_read/pmem_write high at an edge accepts the request.
  - On acceptance, latch op, index and wdata; busy = 1.
  - If LATENCY == 1, next state is RESP; otherwise BUSY, with a counter loaded so that RESP is entered on the LATENCY-th edge after acceptance.
- BUSY:
  - Counter decrements each edge; next state is RESP when it expires.
  - Changes to address or wdata during BUSY are ignored; the latched copies are used.
  - If the accepted request line deasserts, or the opposite request asserts, at any BUSY edge: abort. Return to IDLE, perform no write commit, set protocol_error.
- Entry into RESP, on the same edge:
  - Write: storage[index] is updated with the latched wdata.
  - Read: pmem_rdata is loaded from storage[index].
- RESP:
  - pmem_resp = 1 for exactly one cycle; next state is IDLE unconditionally.
  - pmem_rdata holds its value until the next read enters RESP. Writes do not change it.
- Back-to-back operation:
  - The cycle after RESP is IDLE and samples requests normally, so writeback-then-allocate (pmem_write, resp, pmem_read next cycle) is accepted with no bubble beyond the IDLE cycle.
  - A read of a line written by the immediately preceding transaction returns the new data.
  - A request still held high in that IDLE cycle is treated as a new transaction, not an error.
- Both pmem_read and pmem_write high in IDLE: no acceptance, protocol_error set, remain in IDLE.
- Throughput: one transaction per LATENCY+1 cycles maximum.
- pmem_resp is never asserted outside RESP. It is never asserted for an aborted transaction.

Test Plan:
- Reset, LATENCY=4: read address 0x0000_0040 from cycle 0 → pmem_resp high only in cycle 4; pmem_rdata = 0; busy high in cycles 1-4; protocol_error = 0.
- Write 0xA5…A5 to 0x0000_0060, resp, then read 0x0000_007F → read returns 0xA5…A5 (offset bits ignored); each pmem_resp exactly one cycle.
- Writeback→allocate: pmem_write to 0x100 with data D1, then pmem_read to 0x100 asserted in the cycle after resp → two pmem_resp pulses 5 cycles apart; read returns D1.
- Aliasing, DEPTH_LINES=16: write D2 to 0x0000_0000, read 0x0000_0200 → returns D2.
- Abort: pmem_write to 0x20 with data D3, dropped in cycle 2 → no pmem_resp; protocol_error = 1 and sticky; subsequent read of 0x20 returns the prior value, not D3.
- Both read and write high in IDLE → no pmem_resp, busy stays 0, protocol_error = 1. Async rst_n low mid-BUSY → pmem_resp/busy/protocol_error = 0 immediately, storage zeroed.

Source files
------------

// File: rtl/pmem_line_responder.sv
// Line-granular physical-memory responder for the pmem_read/pmem_write/pmem_resp interface.
// Accepts one whole-line request, completes it LATENCY edges later with a one-cycle pmem_resp.
//
// state  | meaning
// -------+----------------------------------------------------------------
// S_IDLE | waiting for exactly one of pmem_read/pmem_write
// S_BUSY | request latched, latency counter running, request lines watched
// S_RESP | pmem_resp high for one cycle; write committed / rdata loaded
module pmem_line_responder #(
  parameter int unsigned LINE_BITS   = 256,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DEPTH_LINES = 16,
  parameter int unsigned LATENCY     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pmem_read,
  input  logic                  pmem_write,
  input  logic [ADDR_WIDTH-1:0] pmem_address,
  input  logic [LINE_BITS-1:0]  pmem_wdata,
  output logic [LINE_BITS-1:0]  pmem_rdata,
  output logic                  pmem_resp,
  output logic                  busy,
  output logic                  protocol_error
);

  localparam int unsigned OFF   = $clog2(LINE_BITS / 8);
  localparam int unsigned IDX   = (DEPTH_LINES > 1) ? $clog2(DEPTH_LINES) : 1;
  localparam int unsigned CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  // BUSY lasts LATENCY-1 cycles; the counter runs LOAD..0 inclusive.
  localparam int unsigned LOAD  = (LATENCY > 1) ? (LATENCY - 2) : 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 op_wr_q, op_wr_d;
  logic [IDX-1:0]       idx_q, idx_d;
  logic [LINE_BITS-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [LINE_BITS-1:0] rdata_q, rdata_d;
  logic                 resp_q, resp_d;
  logic                 busy_q, busy_d;
  logic                 perr_q, perr_d;

  logic [LINE_BITS-1:0] mem_q [DEPTH_LINES];

  logic                 commit_en;
  logic [IDX-1:0]       commit_idx;
  logic [LINE_BITS-1:0] commit_data;
  logic [IDX-1:0]       req_idx;
  logic                 abort;
  logic                 addr_unused;

  assign req_idx     = pmem_address[OFF+IDX-1:OFF];
  assign addr_unused = ^pmem_address;

  always_comb begin
    state_d     = state_q;
    op_wr_d     = op_wr_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    perr_d      = perr_q;
    resp_d      = 1'b0;
    commit_en   = 1'b0;
    commit_idx  = idx_q;
    commit_data = wdata_q;
    abort       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pmem_read ^ pmem_write) begin
          op_wr_d = pmem_write;
          idx_d   = req_idx;
          wdata_d = pmem_wdata;
          cnt_d   = CNT_W'(LOAD);
          if (LATENCY == 1) begin
            // Single-cycle latency: commit/read straight from the live request.
            state_d = S_RESP;
            resp_d  = 1'b1;
            if (pmem_write) begin
              commit_en   = 1'b1;
              commit_idx  = req_idx;
              commit_data = pmem_wdata;
            end else begin
              rdata_d = mem_q[req_idx];
            end
          end else begin
            state_d = S_BUSY;
          end
        end else if (pmem_read && pmem_write) begin
          perr_d = 1'b1;
        end
      end

      S_BUSY: begin
        abort = op_wr_q ? (!pmem_write || pmem_read) : (!pmem_read || pmem_write);
        if (abort) begin
          state_d = S_IDLE;
          perr_d  = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = S_RESP;
          resp_d  = 1'b1;
          if (op_wr_q) begin
            commit_en = 1'b1;
          end else begin
            rdata_d = mem_q[idx_q];
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_wr_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      resp_q  <= 1'b0;
      busy_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_wr_q <= op_wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
      busy_q  <= busy_d;
      perr_q  <= perr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH_LINES); i++) begin
        mem_q[i] <= '0;
      end
    end else if (commit_en) begin
      mem_q[commit_idx] <= commit_data;
    end
  end

  assign pmem_rdata     = rdata_q;
  assign pmem_resp      = resp_q;
  assign busy           = busy_q;
  assign protocol_error = perr_q;

endmodule

// File: tb/tb_pmem_line_responder.sv
// Directed bench for pmem_line_responder with a read-data scoreboard and a line model.
module tb_pmem_line_responder;

  localparam int LAT = 4;

  logic         clk;
  logic         rst_n;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic         busy;
  logic         protocol_error;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_resp_cyc = 0;

  logic [255:0] model [16];
  logic [255:0] exp_q [$];

  pmem_line_responder #(
    .LINE_BITS(256), .ADDR_WIDTH(32), .DEPTH_LINES(16), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .busy(busy), .protocol_error(protocol_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) model[i] = '0;
    exp_q.delete();
  endtask

  // Starts at a negedge, drives one request, follows it to pmem_resp, then drops it.
  task automatic txn(input bit wr, input logic [31:0] a, input logic [255:0] d, input string tag);
    bit got;
    int n;
    @(negedge clk);
    chk({tag, " idle_resp"}, pmem_resp, 0);
    chk({tag, " idle_busy"}, busy, 0);
    pmem_read    = !wr;
    pmem_write   = wr;
    pmem_address = a;
    pmem_wdata   = d;
    if (wr) model[a[8:5]] = d;
    else    exp_q.push_back(model[a[8:5]]);
    got = 0;
    n   = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      // Scramble address/data while busy: the latched copies must be used.
      pmem_address = $urandom;
      pmem_wdata   = {8{$urandom}};
      chk({tag, " busy"}, busy, 1);
      if (pmem_resp) begin
        got = 1;
        chk({tag, " latency"}, n, LAT);
        if (!wr) chk({tag, " rdata"}, pmem_rdata, exp_q.pop_front());
        last_resp_cyc = cyc;
      end
    end
    if (!got) begin
      total++;
      bad++;
      $error("FAIL %s timeout observed=no_resp expected=resp", tag);
      if (!wr) void'(exp_q.pop_front());
    end
    pmem_read  = 0;
    pmem_write = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    pmem_read = 0;
    pmem_write = 0;
    #1;
    chk("reset_resp", pmem_resp, 0);
    chk("reset_busy", busy, 0);
    chk("reset_perr", protocol_error, 0);
    chk("reset_rdata", pmem_rdata, 0);
    @(negedge clk);
    rst_n = 1;
    clear_model();
  endtask

  logic [255:0] d1, d2, d3, d4, dp;
  int c_wr;

  initial begin
    rst_n = 0;
    pmem_read = 0;
    pmem_write = 0;
    pmem_address = '0;
    pmem_wdata = '0;
    d1 = {8{32'h1234_5678}};
    d2 = {8{32'hDEAD_BEEF}};
    d3 = {8{32'h3333_CCCC}};
    d4 = {8{32'h0F0F_7777}};
    dp = {8{32'h5A5A_0101}};
    clear_model();
    do_reset();

    // Read after reset returns zero, 4-cycle latency.
    txn(0, 32'h0000_0040, '0, "rd_reset");
    chk("perr_clean", protocol_error, 0);

    // Write then read with different offset bits.
    txn(1, 32'h0000_0060, {32{8'hA5}}, "wr_a5");
    txn(0, 32'h0000_007F, '0, "rd_a5");

    // Writeback then allocate on the cycle after resp.
    txn(1, 32'h0000_0100, d1, "wb");
    c_wr = last_resp_cyc;
    txn(0, 32'h0000_0100, '0, "alloc");
    chk("wb_alloc_gap", last_resp_cyc - c_wr, 5);

    // Address aliasing above the index bits.
    txn(1, 32'h0000_0000, d2, "alias_wr");
    txn(0, 32'h0000_0200, '0, "alias_rd");
    chk("perr_still_clean", protocol_error, 0);

    // Both requests high in IDLE.
    @(negedge clk);
    pmem_read = 1;
    pmem_write = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("both_resp", pmem_resp, 0);
      chk("both_busy", busy, 0);
    end
    chk("both_perr", protocol_error, 1);
    pmem_read = 0;
    pmem_write = 0;

    do_reset();

    // Abort: write dropped in cycle 2.
    txn(1, 32'h0000_0020, dp, "prior_wr");
    @(negedge clk);
    pmem_write = 1;
    pmem_address = 32'h0000_0020;
    pmem_wdata = d3;
    @(negedge clk);
    chk("abort_busy", busy, 1);
    @(negedge clk);
    pmem_write = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_resp", pmem_resp, 0);
    end
    chk("abort_perr", protocol_error, 1);
    txn(0, 32'h0000_0020, '0, "abort_rd");
    chk("abort_perr_sticky", protocol_error, 1);

    // Async reset mid-BUSY.
    txn(1, 32'h0000_0060, d4, "pre_rst_wr");
    @(negedge clk);
    pmem_write = 1;
    pmem_address = 32'h0000_0100;
    pmem_wdata = d4;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    #2 rst_n = 0;
    pmem_write = 0;
    #1;
    chk("rst_busy_drop", busy, 0);
    chk("rst_perr_drop", protocol_error, 0);
    chk("rst_resp_drop", pmem_resp, 0);
    @(negedge clk);
    rst_n = 1;
    clear_model();
    txn(0, 32'h0000_0060, '0, "zeroed_rd");

    // Async reset while pmem_resp is high.
    txn(1, 32'h0000_0080, d1, "resp_rst_wr");
    @(negedge clk);
    pmem_read = 1;
    pmem_address = 32'h0000_0080;
    for (int i = 0; i < 20 && !pmem_resp; i++) @(negedge clk);
    chk("resp_seen", pmem_resp, 1);
    chk("resp_rdata", pmem_rdata, d1);
    #2 rst_n = 0;
    pmem_read = 0;
    #1;
    chk("resp_rst_drop", pmem_resp, 0);
    chk("resp_rst_rdata", pmem_rdata, 0);
    @(negedge clk);
    rst_n = 1;
    clear_model();
    txn(0, 32'h0000_0080, '0, "zeroed_rd2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
